// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream loader that writes 32-bit words into instruction memory
//
// Purpose: accepts a 16-bit word count N (low byte first) followed by 4*N
// little-endian payload bytes over a valid/ready handshake. Each assembled
// word is written to byte address 4*k. The core is held in reset while a
// session is in progress, and after an aborted session.
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing check
// byte that must equal the mod-256 sum of the payload bytes.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start_i        one-cycle pulse that begins a load session
//   byte_valid_i   byte_data_i is valid
//   byte_data_i    stream byte
//   byte_ready_o   loader accepts a byte this cycle
//   mem_write_o    one-cycle write strobe to instruction memory
//   mem_address_o  word-aligned byte address of the word being written
//   mem_data_o     assembled instruction word
//   cpu_hold_o     holds the core in reset while high
//   busy_o         session in progress
//   done_o         last session completed successfully
//   error_o        last session aborted
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  mem_write_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COUNT_LO = 3'd1;
  localparam logic [2:0] S_COUNT_HI = 3'd2;
  localparam logic [2:0] S_BYTES    = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK    = 3'd7;
  localparam logic [2:0] S_FINISH   = S_CHECK;
`else
  localparam logic [2:0] S_FINISH   = S_DONE;
`endif

  localparam logic [16:0] DEPTH17 = 17'(MEMORY_DEPTH);

  logic [2:0]  state;
  logic [15:0] count;
  logic [15:0] k;
  logic [1:0]  b;
  logic [23:0] word;      // lanes 0..2; lane 3 goes straight into mem_data_o
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  logic        accept;
  logic [15:0] n_word;
  logic        last_word;

  assign accept    = byte_valid_i && byte_ready_o;
  assign n_word    = {byte_data_i, count[7:0]};
  assign last_word = (k == count - 16'd1);

  // All outputs decode from registered state only.
  assign mem_write_o = (state == S_WRITE);
  assign done_o      = (state == S_DONE);
  assign error_o     = (state == S_ERROR);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign byte_ready_o = (state == S_COUNT_LO) || (state == S_COUNT_HI) ||
                        (state == S_BYTES) || (state == S_CHECK);
  assign busy_o       = byte_ready_o || (state == S_WRITE);
`else
  assign byte_ready_o = (state == S_COUNT_LO) || (state == S_COUNT_HI) ||
                        (state == S_BYTES);
  assign busy_o       = byte_ready_o || (state == S_WRITE);
`endif
  assign cpu_hold_o  = busy_o || (state == S_ERROR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      count         <= '0;
      k             <= '0;
      b             <= '0;
      word          <= '0;
      mem_address_o <= '0;
      mem_data_o    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum           <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state <= S_COUNT_LO;
            k     <= '0;
            b     <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum   <= '0;
`endif
          end
        end
        S_COUNT_LO: begin
          if (accept) begin
            count[7:0] <= byte_data_i;
            state      <= S_COUNT_HI;
          end
        end
        S_COUNT_HI: begin
          if (accept) begin
            count[15:8] <= byte_data_i;
            k           <= '0;
            b           <= '0;
            // Range check up front means k can never wrap during payload.
            if (n_word == 16'd0)
              state <= S_FINISH;
            else if ({1'b0, n_word} > DEPTH17)
              state <= S_ERROR;
            else
              state <= S_BYTES;
          end
        end
        S_BYTES: begin
          if (accept) begin
            b <= b + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum <= sum + byte_data_i;
`endif
            case (b)
              2'd0: word[7:0]   <= byte_data_i;
              2'd1: word[15:8]  <= byte_data_i;
              2'd2: word[23:16] <= byte_data_i;
              default: begin
                mem_data_o    <= {byte_data_i, word};
                mem_address_o <= DATA_WIDTH'({k, 2'b00});
                state         <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (last_word) begin
            state <= S_FINISH;
          end else begin
            k     <= k + 16'd1;
            state <= S_BYTES;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept)
            state <= (byte_data_i == sum) ? S_DONE : S_ERROR;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
